// File: rtl/hexagon_render_pkg.sv
// Shared FSM encodings, request record and AXI constants for the renderer's memory-side blocks.
// No logic; imported by burst_write_engine and its helpers.
package hexagon_render_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_RESP = 3'd3,
        ST_DONE = 3'd4
    } bwe_state_t;

    // Beat counts run 0..256, so one bit wider than AXI awlen.
    localparam int BURST_LEN_W = 9;

    typedef struct packed {
        logic [31:0]            addr;
        logic [BURST_LEN_W-1:0] len;
        logic [31:0]            color;
    } burst_req_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/rise_pulse.sv
// Registered rising-edge detector: one-cycle pulse after level goes from low to high.
// Latency 1 cycle from the sampled rise; no backpressure, an unconsumed pulse is simply lost.
// Holding level high never produces a second pulse.
module rise_pulse
    import hexagon_render_pkg::*;
(
    input  logic clk100,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic level_q;

    always_ff @(posedge clk100) begin
        if (reset) begin
            level_q <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            level_q <= level;
            pulse   <= level & ~level_q;
        end
    end

endmodule

// File: rtl/burst_write_engine.sv
// One txn_init rise -> one AXI4 INCR fill burst of min(pixel_count,MAX_BURST_LEN) beats; BRESP_ERR_EN adds sticky err.
// Latency: request edge to txn_done is 3+len cycles with an always-ready slave, 1 cycle for len 0.
// Backpressure: AW/W payloads are registered and held while valid && !ready; new requests ignored while busy.
module burst_write_engine
    import hexagon_render_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'h1000_0000,
    parameter int unsigned MAX_BURST_LEN = 256
) (
    input  logic        clk100,
    input  logic        reset,
    input  logic        txn_init,
    input  logic [31:0] offset_addr,
    input  logic [31:0] pixel_count,
    input  logic [31:0] color,
    output logic        txn_done,
    output logic        busy,
    output logic [31:0] m_axi_awaddr,
    output logic [7:0]  m_axi_awlen,
    output logic [2:0]  m_axi_awsize,
    output logic [1:0]  m_axi_awburst,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wlast,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic        err
);

    localparam logic [BURST_LEN_W-1:0] LEN_MAX = BURST_LEN_W'(MAX_BURST_LEN);
    localparam logic [BURST_LEN_W-1:0] LEN_ONE = BURST_LEN_W'(1);
    localparam logic [BURST_LEN_W-1:0] LEN_TWO = BURST_LEN_W'(2);

    bwe_state_t             state;
    burst_req_t             req;
    logic [BURST_LEN_W-1:0] beat_cnt;
    logic [BURST_LEN_W-1:0] req_len;
    logic                   init_pulse;

    rise_pulse u_init_edge (
        .clk100 (clk100),
        .reset  (reset),
        .level  (txn_init),
        .pulse  (init_pulse)
    );

    assign req_len = (pixel_count > 32'(MAX_BURST_LEN)) ? LEN_MAX : pixel_count[BURST_LEN_W-1:0];

    assign m_axi_awaddr  = req.addr;
    assign m_axi_awlen   = 8'(req.len - LEN_ONE);
    assign m_axi_awsize  = AXI_SIZE_4B;
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_wdata   = req.color;
    assign m_axi_wstrb   = 4'hF;

    always_ff @(posedge clk100) begin
        if (reset) begin
            state         <= ST_IDLE;
            req           <= '0;
            beat_cnt      <= '0;
            txn_done      <= 1'b0;
            busy          <= 1'b0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_wlast   <= 1'b0;
            m_axi_bready  <= 1'b0;
        end else begin
            txn_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (init_pulse) begin
                        req.addr  <= BASE_ADDR + offset_addr;
                        req.len   <= req_len;
                        req.color <= color;
                        beat_cnt  <= '0;
                        busy      <= 1'b1;
                        if (req_len == '0) begin
                            state    <= ST_DONE;
                            txn_done <= 1'b1;
                        end else begin
                            state         <= ST_ADDR;
                            m_axi_awvalid <= 1'b1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (m_axi_awready) begin
                        m_axi_awvalid <= 1'b0;
                        m_axi_wvalid  <= 1'b1;
                        m_axi_wlast   <= (req.len == LEN_ONE);
                        state         <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (m_axi_wready) begin
                        beat_cnt <= beat_cnt + LEN_ONE;
                        if (m_axi_wlast) begin
                            m_axi_wvalid <= 1'b0;
                            m_axi_wlast  <= 1'b0;
                            m_axi_bready <= 1'b1;
                            state        <= ST_RESP;
                        end else begin
                            // wlast must already be up for the beat after this one
                            m_axi_wlast <= (beat_cnt + LEN_TWO == req.len);
                        end
                    end
                end
                ST_RESP: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        txn_done     <= 1'b1;
                        state        <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef BRESP_ERR_EN
    always_ff @(posedge clk100) begin
        if (reset) begin
            err <= 1'b0;
        end else if (m_axi_bvalid && m_axi_bready && (m_axi_bresp != AXI_RESP_OKAY)) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0 & (|m_axi_bresp);
`endif

endmodule
